// File: rtl/inertial_scan_pkg.sv
// Shared types and width helpers for the inertial scan scheduler.
package inertial_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        CLEAR = 2'd2
    } scan_state_t;

    // Event channel field is sized for the largest supported N_CH (16).
    localparam int EVT_CH_W = 4;

    typedef struct packed {
        logic [EVT_CH_W-1:0] ch;
        logic                level;
    } scan_evt_t;

    // Width of a per-channel consecutive-mismatch counter (never below 1 bit).
    function automatic int cnt_width(input int consec_count);
        return (consec_count > 2) ? $clog2(consec_count) : 1;
    endfunction

    // Width of the channel index (never below 1 bit).
    function automatic int ch_width(input int n_ch);
        return (n_ch > 2) ? $clog2(n_ch) : 1;
    endfunction

endpackage

// File: rtl/inertial_scan_scheduler_tick_gen.sv
// Prescaler producing a one-clock sample tick every PRESCALE enabled clocks.
module sample_tick_gen #(
    parameter int PRESCALE = 5000
) (
    input  logic clk,
    input  logic asynch_reset_n,
    input  logic enable,
    output logic tick
);

    localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] pcnt;

    assign tick = enable && (pcnt == PW'(PRESCALE - 1));

    // Count while enabled, hold while disabled, wrap on tick.
    always_ff @(posedge clk or negedge asynch_reset_n) begin
        if (!asynch_reset_n) begin
            pcnt <= '0;
        end else if (enable) begin
            pcnt <= tick ? '0 : pcnt + 1'b1;
        end
    end

endmodule

// File: rtl/inertial_scan_scheduler.sv
// Time-multiplexed inertial filter: one shared compare/increment path scans
// all channels once per sample round and reports level changes as events.
module inertial_scan_scheduler
    import inertial_scan_pkg::*;
#(
    parameter int N_CH         = 4,
    parameter int CONSEC_COUNT = 10,
    parameter int PRESCALE     = 5000
) (
    input  logic                      clk,
    input  logic                      asynch_reset_n,
    input  logic                      enable,
    input  logic                      synch_clear,
    input  logic [N_CH-1:0]           raw_in,
    output logic [N_CH-1:0]           filt_out,
    output logic                      evt_valid,
    input  logic                      evt_ready,
    output logic [ch_width(N_CH)-1:0] evt_ch,
    output logic                      evt_level,
    output logic                      busy,
    output logic                      overflow
);

    localparam int CW  = cnt_width(CONSEC_COUNT);
    localparam int CHW = ch_width(N_CH);

    if (PRESCALE < N_CH + 2 || N_CH < 2 || N_CH > 16 ||
        CONSEC_COUNT < 2 || CONSEC_COUNT > 255) begin : g_param_check
        $error("inertial_scan_scheduler: illegal parameters (need PRESCALE >= N_CH+2)");
    end

    logic              tick;
    logic [N_CH-1:0]   sync1, sync2, snap;
    logic [CW-1:0]     cnt [N_CH];
    scan_state_t       state;
    logic [CHW-1:0]    ch_idx;
    logic              clear_pend;
    scan_evt_t         evt_q;

    // Shared datapath: everything below looks only at the channel under ch_idx.
    logic [CW-1:0] cur_cnt;
    logic          cur_snap, cur_filt, mismatch, at_max, last_ch, fire;

    assign cur_cnt  = cnt[ch_idx];
    assign cur_snap = snap[ch_idx];
    assign cur_filt = filt_out[ch_idx];
    assign mismatch = cur_snap != cur_filt;
    assign at_max   = cur_cnt == CW'(CONSEC_COUNT - 1);
    assign last_ch  = ch_idx == CHW'(N_CH - 1);
    assign fire     = (state == SCAN) && mismatch && at_max;

    assign evt_ch    = evt_q.ch[CHW-1:0];
    assign evt_level = evt_q.level;

    // Upper event-channel bits stay zero for narrow configurations.
    logic unused_evt_hi;
    assign unused_evt_hi = ^evt_q.ch;

    sample_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
        .clk            (clk),
        .asynch_reset_n (asynch_reset_n),
        .enable         (enable),
        .tick           (tick)
    );

    // Two-flop synchronizer on every raw input bit.
    always_ff @(posedge clk or negedge asynch_reset_n) begin
        if (!asynch_reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw_in;
            sync2 <= sync1;
        end
    end

    // Round sequencer: snapshot on tick, walk ch_idx across all channels.
    // clear_pend comes out of reset set so the first round reloads outputs.
    always_ff @(posedge clk or negedge asynch_reset_n) begin
        if (!asynch_reset_n) begin
            state      <= IDLE;
            ch_idx     <= '0;
            snap       <= '0;
            busy       <= 1'b0;
            clear_pend <= 1'b1;
        end else begin
            if (synch_clear) clear_pend <= 1'b1;
            case (state)
                IDLE: begin
                    if (tick) begin
                        snap   <= sync2;
                        ch_idx <= '0;
                        busy   <= 1'b1;
                        state  <= clear_pend ? CLEAR : SCAN;
                        // A clear arriving on the start cycle is kept for the next round.
                        if (clear_pend) clear_pend <= synch_clear;
                    end
                end
                SCAN, CLEAR: begin
                    if (last_ch) begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        ch_idx <= '0;
                    end else begin
                        ch_idx <= ch_idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Per-channel filter state update for the channel under ch_idx.
    always_ff @(posedge clk or negedge asynch_reset_n) begin
        if (!asynch_reset_n) begin
            for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
            filt_out <= '0;
        end else if (state == CLEAR) begin
            cnt[ch_idx]      <= '0;
            filt_out[ch_idx] <= cur_snap;
        end else if (state == SCAN) begin
            if (!mismatch) begin
                cnt[ch_idx] <= '0;
            end else if (at_max) begin
                cnt[ch_idx]      <= '0;
                filt_out[ch_idx] <= cur_snap;
            end else begin
                cnt[ch_idx] <= cur_cnt + 1'b1;
            end
        end
    end

    // One-entry event holding register; a full, unaccepted register drops the new event.
    always_ff @(posedge clk or negedge asynch_reset_n) begin
        if (!asynch_reset_n) begin
            evt_valid <= 1'b0;
            evt_q     <= '0;
            overflow  <= 1'b0;
        end else if (fire) begin
            if (!evt_valid || evt_ready) begin
                evt_valid <= 1'b1;
                evt_q     <= '{ch: EVT_CH_W'(ch_idx), level: cur_snap};
            end else begin
                overflow <= 1'b1;
            end
        end else if (evt_valid && evt_ready) begin
            evt_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_inertial_scan_scheduler.sv
// Directed bench for inertial_scan_scheduler (N_CH=4, CONSEC_COUNT=10, PRESCALE=8).
module tb_inertial_scan_scheduler;

    logic       clk = 1'b0;
    logic       asynch_reset_n = 1'b0;
    logic       enable = 1'b0;
    logic       synch_clear = 1'b0;
    logic       evt_ready = 1'b0;
    logic [3:0] raw_in = 4'b0000;
    logic [3:0] filt_out;
    logic       evt_valid;
    logic [1:0] evt_ch;
    logic       evt_level;
    logic       busy;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    int         acc_cnt = 0;
    int         vld_cycles = 0;
    logic [1:0] last_ch = 2'd0;
    logic       last_lvl = 1'b0;

    always #5 clk = ~clk;

    inertial_scan_scheduler #(
        .N_CH(4), .CONSEC_COUNT(10), .PRESCALE(8)
    ) dut (
        .clk            (clk),
        .asynch_reset_n (asynch_reset_n),
        .enable         (enable),
        .synch_clear    (synch_clear),
        .raw_in         (raw_in),
        .filt_out       (filt_out),
        .evt_valid      (evt_valid),
        .evt_ready      (evt_ready),
        .evt_ch         (evt_ch),
        .evt_level      (evt_level),
        .busy           (busy),
        .overflow       (overflow)
    );

    // Event monitor: samples just before the rising edge.
    always @(negedge clk) begin
        #2;
        if (evt_valid) vld_cycles++;
        if (evt_valid && evt_ready) begin
            acc_cnt++;
            last_ch  = evt_ch;
            last_lvl = evt_level;
        end
    end

    // Wait for a round to start and finish; ends on the first idle negedge.
    task automatic wait_round_end();
        int n;
        n = 0;
        while (!busy && n < 40) begin @(negedge clk); n++; end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL round_start_timeout busy=%b want=1", busy); end
        n = 0;
        while (busy && n < 40) begin @(negedge clk); n++; end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL round_end_timeout busy=%b want=0", busy); end
    endtask

    task automatic run_rounds(input int n);
        for (int r = 0; r < n; r++) wait_round_end();
    endtask

    task automatic test_reset();
        int a0, v0;
        raw_in = 4'b1010; enable = 1'b1; evt_ready = 1'b1; asynch_reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({filt_out, evt_valid, busy, overflow, evt_ch, evt_level} !== 10'd0) begin
            errors++; $display("FAIL reset_outputs got=%b want=0", {filt_out, evt_valid, busy, overflow, evt_ch, evt_level});
        end
        asynch_reset_n = 1'b1;
        a0 = acc_cnt; v0 = vld_cycles;
        wait_round_end();
        checks++;
        if (filt_out !== 4'b1010) begin errors++; $display("FAIL reset_clear_filt got=%b want=1010", filt_out); end
        checks++;
        if (vld_cycles - v0 != 0 || acc_cnt - a0 != 0) begin
            errors++; $display("FAIL reset_clear_no_evt got=%0d want=0", vld_cycles - v0);
        end
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b want=0", overflow); end
    endtask

    task automatic test_sustained_change();
        int a0, v0, n;
        raw_in = 4'b1110; evt_ready = 1'b1;
        a0 = acc_cnt; v0 = vld_cycles;
        run_rounds(9);
        checks++;
        if (filt_out !== 4'b1010 || acc_cnt != a0) begin
            errors++; $display("FAIL ch2_after9 filt=%b evts=%0d want filt=1010 evts=0", filt_out, acc_cnt - a0);
        end
        n = 0;
        while (!busy && n < 40) begin @(negedge clk); n++; end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL ch2_round10_start busy=%b want=1", busy); end
        @(negedge clk); @(negedge clk);
        checks++;
        if (filt_out[2] !== 1'b0 || evt_valid !== 1'b0) begin
            errors++; $display("FAIL ch2_T3 filt2=%b vld=%b want 0 0", filt_out[2], evt_valid);
        end
        @(negedge clk);
        checks++;
        if (filt_out !== 4'b1110) begin errors++; $display("FAIL ch2_T4_filt got=%b want=1110", filt_out); end
        checks++;
        if (evt_valid !== 1'b1 || evt_ch !== 2'd2 || evt_level !== 1'b1) begin
            errors++; $display("FAIL ch2_T4_evt got=%b/%0d/%b want=1/2/1", evt_valid, evt_ch, evt_level);
        end
        @(negedge clk);
        checks++;
        if (evt_valid !== 1'b0) begin errors++; $display("FAIL ch2_T5_vld got=%b want=0", evt_valid); end
        checks++;
        if (acc_cnt - a0 != 1 || vld_cycles - v0 != 1 || last_ch !== 2'd2 || last_lvl !== 1'b1) begin
            errors++; $display("FAIL ch2_evt_count acc=%0d vld=%0d ch=%0d lvl=%b want 1 1 2 1",
                               acc_cnt - a0, vld_cycles - v0, last_ch, last_lvl);
        end
    endtask

    task automatic test_glitch();
        int a0;
        a0 = acc_cnt;
        raw_in = 4'b1111;
        run_rounds(9);
        raw_in = 4'b1110;
        run_rounds(1);
        checks++;
        if (filt_out !== 4'b1110 || acc_cnt != a0) begin
            errors++; $display("FAIL glitch9_filt got=%b evts=%0d want=1110 0", filt_out, acc_cnt - a0);
        end
        raw_in = 4'b1111;
        run_rounds(9);
        checks++;
        if (filt_out[0] !== 1'b0) begin errors++; $display("FAIL glitch_restart got=%b want=0", filt_out[0]); end
        run_rounds(1);
        checks++;
        if (filt_out !== 4'b1111) begin errors++; $display("FAIL glitch10_filt got=%b want=1111", filt_out); end
        checks++;
        if (acc_cnt - a0 != 1 || last_ch !== 2'd0 || last_lvl !== 1'b1) begin
            errors++; $display("FAIL glitch10_evt acc=%0d ch=%0d lvl=%b want 1 0 1", acc_cnt - a0, last_ch, last_lvl);
        end
    endtask

    task automatic test_overflow();
        int a0;
        a0 = acc_cnt;
        evt_ready = 1'b0;
        raw_in = 4'b0101;
        run_rounds(9);
        checks++;
        if (filt_out !== 4'b1111 || evt_valid !== 1'b0) begin
            errors++; $display("FAIL ovf_after9 filt=%b vld=%b want 1111 0", filt_out, evt_valid);
        end
        run_rounds(1);
        checks++;
        if (filt_out !== 4'b0101) begin errors++; $display("FAIL ovf_filt got=%b want=0101", filt_out); end
        checks++;
        if (evt_valid !== 1'b1 || evt_ch !== 2'd1 || evt_level !== 1'b0) begin
            errors++; $display("FAIL ovf_held got=%b/%0d/%b want=1/1/0", evt_valid, evt_ch, evt_level);
        end
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b want=1", overflow); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (evt_valid !== 1'b1 || evt_ch !== 2'd1 || evt_level !== 1'b0) begin
                errors++; $display("FAIL ovf_stable%0d got=%b/%0d/%b want=1/1/0", i, evt_valid, evt_ch, evt_level);
            end
        end
        evt_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (evt_valid !== 1'b0 || overflow !== 1'b1) begin
            errors++; $display("FAIL ovf_accept vld=%b ovf=%b want 0 1", evt_valid, overflow);
        end
        wait_round_end();
        checks++;
        if (acc_cnt - a0 != 1 || last_ch !== 2'd1 || overflow !== 1'b1) begin
            errors++; $display("FAIL ovf_count acc=%0d ch=%0d ovf=%b want 1 1 1", acc_cnt - a0, last_ch, overflow);
        end
    endtask

    task automatic test_synch_clear();
        int a0;
        evt_ready = 1'b1;
        raw_in = 4'b0001;
        run_rounds(7);
        checks++;
        if (filt_out !== 4'b0101) begin errors++; $display("FAIL clr_pre got=%b want=0101", filt_out); end
        synch_clear = 1'b1;
        @(negedge clk);
        synch_clear = 1'b0;
        a0 = acc_cnt;
        wait_round_end();
        checks++;
        if (filt_out !== 4'b0001 || acc_cnt != a0 || evt_valid !== 1'b0) begin
            errors++; $display("FAIL clr_round filt=%b evts=%0d vld=%b want 0001 0 0", filt_out, acc_cnt - a0, evt_valid);
        end
        raw_in = 4'b0101;
        run_rounds(9);
        checks++;
        if (filt_out !== 4'b0001 || acc_cnt != a0) begin
            errors++; $display("FAIL clr_cnt_zeroed filt=%b evts=%0d want 0001 0", filt_out, acc_cnt - a0);
        end
        run_rounds(1);
        checks++;
        if (filt_out !== 4'b0101 || acc_cnt - a0 != 1 || last_ch !== 2'd2 || last_lvl !== 1'b1) begin
            errors++; $display("FAIL clr_post10 filt=%b acc=%0d ch=%0d lvl=%b want 0101 1 2 1",
                               filt_out, acc_cnt - a0, last_ch, last_lvl);
        end
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL clr_ovf_sticky got=%b want=1", overflow); end
    endtask

    task automatic test_reset_mid_round();
        int a0, n;
        n = 0;
        while (!busy && n < 40) begin @(negedge clk); n++; end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_start busy=%b want=1", busy); end
        @(negedge clk);
        #1 asynch_reset_n = 1'b0;
        #1;
        checks++;
        if ({filt_out, evt_valid, busy, overflow, evt_ch, evt_level} !== 10'd0) begin
            errors++; $display("FAIL rstmid_outputs got=%b want=0", {filt_out, evt_valid, busy, overflow, evt_ch, evt_level});
        end
        @(negedge clk); @(negedge clk);
        asynch_reset_n = 1'b1;
        a0 = acc_cnt;
        wait_round_end();
        checks++;
        if (filt_out !== 4'b0101 || acc_cnt != a0 || overflow !== 1'b0) begin
            errors++; $display("FAIL rstmid_clear filt=%b evts=%0d ovf=%b want 0101 0 0", filt_out, acc_cnt - a0, overflow);
        end
    endtask

    initial begin
        test_reset();
        test_sustained_change();
        test_glitch();
        test_overflow();
        test_synch_clear();
        test_reset_mid_round();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
